// File: rtl/calc_op_sequencer_pkg.sv
// Shared op codes, FSM state encodings and width helpers for the calculator sequencer.
package calc_op_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DEF_WIDTH = 4;

    function automatic int unsigned res_width(input int unsigned w);
        return 2 * w;
    endfunction

    // Step counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Command/response handshake bundle between the calculator front end and the sequencer.
interface calc_op_sequencer_if
    import calc_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RES_W = res_width(WIDTH)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_result;
    logic [WIDTH-1:0] rsp_rem;
    logic             rsp_err;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_rem, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_rem, rsp_err, busy
    );
endinterface

// File: rtl/calc_op_sequencer_iter.sv
// Iterative datapath: restoring divider / shift-add multiplier sharing one accumulator.
module calc_iter_unit
    import calc_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RES_W = res_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [RES_W-1:0] result_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int unsigned CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        div_d     = div_q;
        mul_sum   = {1'b0, acc_q[RES_W-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = acc_q[RES_W-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m_q};
        if (load_i) begin
            cnt_d = CW'(WIDTH);
            acc_d = {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
            m_d   = div_i ? b_i : a_i;
            div_d = div_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (div_q) begin
                if (div_shift >= {1'b0, m_q}) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign last_o   = (cnt_q == CW'(1));
    assign result_o = div_q ? {{(RES_W-WIDTH){1'b0}}, acc_d[WIDTH-1:0]} : acc_d;
    assign rem_o    = div_q ? acc_d[RES_W-1:WIDTH] : '0;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator op sequencer: accepts one command, runs add/sub directly or div/mul iteratively, holds result.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RES_W = res_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    calc_op_sequencer_if.slave bus
);
    localparam int unsigned PADW = RES_W - WIDTH;

    logic [1:0]       state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             accept;
    logic             iter_load;
    logic             iter_last;
    logic [RES_W-1:0] iter_result;
    logic [WIDTH-1:0] iter_rem;
    logic [RES_W-1:0] a_ext, b_ext;

    assign accept    = bus.cmd_valid && (state_q == ST_IDLE);
    assign iter_load = accept && ((bus.cmd_op == OP_MUL) ||
                                  ((bus.cmd_op == OP_DIV) && (bus.cmd_b != '0)));
    assign a_ext     = {{PADW{1'b0}}, bus.cmd_a};
    assign b_ext     = {{PADW{1'b0}}, bus.cmd_b};

    calc_iter_unit #(
        .WIDTH (WIDTH),
        .RES_W (RES_W)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (iter_load),
        .div_i    (bus.cmd_op == OP_DIV),
        .a_i      (bus.cmd_a),
        .b_i      (bus.cmd_b),
        .last_o   (iter_last),
        .result_o (iter_result),
        .rem_o    (iter_rem)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    case (bus.cmd_op)
                        OP_ADD: begin
                            result_d = a_ext + b_ext;
                            rem_d    = '0;
                            state_d  = ST_DONE;
                        end
                        OP_SUB: begin
                            result_d = a_ext - b_ext;
                            rem_d    = '0;
                            state_d  = ST_DONE;
                        end
                        OP_DIV: begin
                            if (bus.cmd_b == '0) begin
                                result_d = '1;
                                rem_d    = bus.cmd_a;
                                err_d    = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                state_d  = ST_ITER;
                            end
                        end
                        default: state_d = ST_ITER;
                    endcase
                end
            end
            ST_ITER: begin
                // Capture the unit's post-step value so the result lands on the same edge as the last step.
                if (iter_last) begin
                    result_d = iter_result;
                    rem_d    = iter_rem;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.rsp_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_rem    = rem_q;
    assign bus.rsp_err    = err_q;

endmodule
